// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALUOp, mux selects, states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_multicycle_ctrl_pkg;

   // Opcodes as found in instr[31:26]
   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   // ALUOp encoding, shared with the existing ALU control block
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Controller states; encodings 11-15 are unused and recover to IDLE
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXEC   = 4'd7,
      ST_RWB    = 4'd8,
      ST_BRANCH = 4'd9,
      ST_JUMP   = 4'd10
   } state_t;

   // Bundle of decoded datapath controls
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control decoder for the multicycle MIPS controller.
// Latency: 0 cycles (pure decode of the current state).
// Backpressure: mem_ready only gates the FETCH-phase IR/PC loads; everything else holds with the state.
module mips_ctrl_outdec
   import mips_multicycle_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // Moore decode; IR and PC loads in FETCH wait for the memory to deliver the word
   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         ST_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         ST_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         ST_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         ST_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ST_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, flags illegal opcodes, counts retirements.
// Latency: LW 5, SW 4, R 4, BEQ 3, J 3 cycles with mem_ready high; illegal_op one cycle after DECODE.
// Backpressure: FETCH, MEMRD and MEMWR hold state and outputs until mem_ready=1.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   ctrl_t            ctrl;

   // Next state, illegal-opcode detection and retirement accounting
   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      retire    = 1'b0;
      case (state_q)
         ST_IDLE:   if (run) state_d = ST_FETCH;
         ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_R:         state_d = ST_EXEC;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               default: begin
                  // Undecodable: skip to the next fetch without retiring
                  state_d   = ST_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_MEMADR: state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
         ST_MEMWB: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_MEMWR: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_EXEC:   state_d = ST_RWB;
         ST_RWB, ST_BRANCH, ST_JUMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         default:   state_d = ST_IDLE;
      endcase
      retired_d = retire ? (retired_q + CNT_ONE) : retired_q;
   end

   // State, illegal flag and counter registers; reset returns to IDLE at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   mips_ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign illegal_op    = illegal_q;
   assign state_o       = state_q;
   assign retired       = retired_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Sequential (Moore) control unit for the multicycle MIPS datapath.
- Consumes the opcode latched in the instruction register and sequences the datapath one phase per cycle: fetch, decode, execute, memory, writeback.
- The existing single-cycle decoder maps opcode to control signals combinationally; this block is its stateful counterpart and drives the same ALUOp encoding into the existing ALU control.
- Adds a memory ready handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue enable, sampled in IDLE only.
- op  in  6  opcode from the IR (instr[31:26]).
- mem_ready  in  1  memory completed the access requested this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination select: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B select: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
- alu_op  out  2  00=add, 01=subtract, 10=use funct.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- state_o  out  4  current state, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, retired=0, illegal_op=0. All decoded outputs are 0 in IDLE.
- Outputs are a pure function of state (Moore), except illegal_op, which is registered.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010.
- State encodings and outputs (signals not listed are 0):
  - IDLE=0: no outputs. Stay while run=0; go to FETCH when run=1.
  - FETCH=1: mem_read, ir_write, alu_src_b=01, alu_op=00, pc_write, pc_source=00. ir_write and pc_write take effect only in the cycle mem_ready=1 (gate with mem_ready). Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE=2: alu_src_b=11, alu_op=00. Next state by op:
    - LW/SW: MEMADR
    - R: EXEC
    - BEQ: BRANCH
    - J: JUMP
    - any other op: FETCH, with illegal_op=1 for exactly the next cycle. retired is not incremented.
  - MEMADR=3: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if op=LW, else MEMWR.
  - MEMRD=4: mem_read, i_or_d=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB=5: reg_write, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEMWR=6: mem_write, i_or_d=1. Wait for mem_ready, then go to FETCH.
  - EXEC=7: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
  - RWB=8: reg_write, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH=9: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Go to FETCH.
  - JUMP=10: pc_write, pc_source=10. Go to FETCH.
- Unused encodings 11-15 go to IDLE on the next edge, with outputs 0.
- retired increments by 1 on each transition from MEMWB, MEMWR (on mem_ready), RWB, BRANCH or JUMP into FETCH. It wraps from all-ones to 0.
- Cycle counts with mem_ready tied high: LW=5, SW=4, R=4, BEQ=3, J=3.
- run is ignored outside IDLE. The controller only returns to IDLE via reset or an illegal state.
- Reset asserted mid-instruction aborts immediately. No write strobes are asserted while rst_n=0.
- The handshake holds all outputs stable while waiting on mem_ready.

Decomposition:
- Shared package holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - state encoding constants
  - alu_src_b and pc_source select constants
- The existing ALU control block consumes alu_op.
- One natural sub-module: mips_ctrl_outdec, the combinational state-to-output decoder. The top level holds the state register, next-state logic and the counter.

Test Plan:
- Reset and run: rst_n=0, then release with run=0 for 5 cycles → state_o=0 and all outputs 0. Set run=1 → state_o=1 next cycle, with mem_read=1, alu_src_b=01.
- LW, mem_ready=1: op=100011 → states 1,2,3,4,5,1. In MEMWB, reg_write=1 and mem_to_reg=1. retired goes 0→1 on re-entry to FETCH.
- SW with stall: op=101011, mem_ready held low for 3 cycles in MEMWR → state holds 6 with mem_write=1 for 4 cycles. retired increments only after mem_ready=1.
- R-type then BEQ then J: states 1,2,7,8 / 1,2,9 / 1,2,10. In BRANCH, alu_op=01 and pc_write_cond=1. In JUMP, pc_source=10. retired=3 at the end.
- Illegal op=111111 → DECODE goes to FETCH, illegal_op high for exactly one cycle, retired unchanged.
- Async reset during MEMRD (mid-cycle rst_n=0) → state_o=0 and mem_read=0 immediately, without waiting for a clock edge. retired=0.
